mem_responder: RTL and testbench
================================

# mem_responder

Word-organised RAM that answers the CPU's memory strobe interface: samples `mem_init` with read/write op, address and write data, waits a fixed number of cycles, then pulses `mem_ready` with load data. Serves both instruction fetch and load/store traffic, sitting directly on the CPU's memory port as the responder for every access the CPU initiates.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; valid word index is `addr[31:2] < DEPTH`.
- `LATENCY`, 2: cycles from `mem_init` to `mem_ready`; legal range 1..15.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; low forces all control state and outputs to reset values.
- `mem_init` in 1: one-cycle request strobe.
- `mem_read_op` in 3: bit2 = unsigned, bits[1:0] size (00 none, 01 byte, 10 half, 11 word).
- `mem_write_op` in 2: size (00 none, 01 byte, 10 half, 11 word).
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `mem_ready` out 1: one-cycle completion pulse.
- `rdata` out 32: load data, valid in `mem_ready` cycle and held until next accepted request.
- `misaligned` out 1: sticky misalignment flag (see Configuration).

## Operation
- States: IDLE, WAIT, RESP. Request accepted only when `mem_init`=1 in IDLE; `mem_read_op`, `mem_write_op`, `addr`, `wdata` captured that cycle. Inputs ignored afterwards.
- IDLE -> RESP if LATENCY=1, else IDLE -> WAIT with counter = LATENCY-2; WAIT decrements, -> RESP at 0; RESP -> IDLE unconditionally.
- `mem_init` in WAIT or RESP ignored (no queueing).
- Access performed at the edge entering RESP: RAM write committed, read data captured into `rdata`.
- Little-endian lanes. Byte: lane `addr[1:0]`; half: lane `addr[1]`; word: whole word.
- Read: selected byte/half sign-extended (bit2=0) or zero-extended (bit2=1); word ignores bit2. `mem_read_op[1:0]`=00 with write: `rdata` = 0.
- Write: `wdata[7:0]` / `wdata[15:0]` / `wdata` to selected lane(s); other bytes unchanged.
- Both read and write nonzero: illegal; no write, `rdata` = 0, `mem_ready` still pulses.
- Both zero: no-op, `rdata` = 0, `mem_ready` pulses.
- Out of range (`addr[31:2] >= DEPTH`): write dropped, read returns 0; no wrap.
- Misaligned half/word without align check: low address bits below access size ignored (forced alignment).

## Timing
- Reset values: state IDLE, counter 0, `mem_ready` 0, `rdata` 0, `misaligned` 0. RAM contents not reset.
- `mem_init` in cycle 0 -> `mem_ready` high in cycle LATENCY, exactly one cycle.
- Next request accepted earliest in cycle LATENCY+1; minimum request spacing LATENCY+1.
- Read-after-write: write in transaction N visible to any read in transaction N+1.
- Reset asserted mid-transaction: transaction abandoned, no `mem_ready`; write not committed if reset precedes the RESP-entry edge.

## Configuration
- `MEM_RESPONDER_ALIGN_CHECK_EN` defined: half access with `addr[0]`=1 or word access with `addr[1:0]`!=0 is suppressed (no write, `rdata` = 0), `mem_ready` still pulses, `misaligned` set and held until reset.
- Undefined: forced alignment as above; `misaligned` tied 0.

## Test plan
- Reset, then SW `addr`=0x10 `wdata`=0x8081_82F3, LATENCY=2 -> `mem_ready` exactly in cycle 2; LW 0x10 returns 0x8081_82F3.
- Byte/half extension on that word: LB 0x10 -> 0xFFFF_FFF3, LBU 0x10 -> 0x0000_00F3, LH 0x12 -> 0xFFFF_8081, LHU 0x12 -> 0x0000_8081.
- SB 0x11 `wdata`=0xAA then SH 0x12 `wdata`=0x1234 -> LW 0x10 returns 0x1234_AAF3.
- `mem_init` held high in WAIT/RESP and out-of-range LW at `DEPTH*4` -> single `mem_ready` per accepted request; read returns 0; SW there leaves word 0 unchanged.
- Reset pulsed low in WAIT of SW 0x20 `wdata`=0x5555_5555 -> no `mem_ready`; subsequent LW 0x20 returns prior contents.
- LW 0x13: with `MEM_RESPONDER_ALIGN_CHECK_EN` -> `rdata`=0, `misaligned`=1; without -> returns word at 0x10, `misaligned`=0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder
//   Word-organised RAM that answers a CPU memory strobe interface. A request
//   strobed on mem_init in IDLE is captured, the access happens LATENCY cycles
//   later, and mem_ready pulses for exactly one cycle with the load data on
//   rdata. rdata holds its value until the next accepted request completes.
//
//   Optional feature: define MEM_RESPONDER_ALIGN_CHECK_EN to suppress
//   misaligned half/word accesses and raise the sticky `misaligned` flag.
//   Without it, misaligned accesses are force-aligned and `misaligned` is 0.
//
// Parameters
//   DEPTH   : RAM size in 32-bit words (word index addr[31:2] < DEPTH)
//   LATENCY : cycles from mem_init to mem_ready, 1..15
// Ports
//   clk          in  : clock, all state on the rising edge
//   reset        in  : asynchronous, active-low reset
//   mem_init     in  : one-cycle request strobe
//   mem_read_op  in 3: bit2 unsigned, [1:0] size (00 none, 01 B, 10 H, 11 W)
//   mem_write_op in 2: size (00 none, 01 B, 10 H, 11 W)
//   addr         in32: byte address
//   wdata        in32: store data, right-aligned
//   mem_ready    out : one-cycle completion pulse
//   rdata        out32: load data
//   misaligned   out : sticky misalignment flag
module mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_init,
  input  logic [2:0]  mem_read_op,
  input  logic [1:0]  mem_write_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_ready,
  output logic [31:0] rdata,
  output logic        misaligned
);

  localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WAIT_INIT = 4'((LATENCY >= 2) ? (LATENCY - 2) : 0);
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [3:0]  count_reg, count_next;
  logic        accept;
  logic        enter_resp;

  // Captured request
  logic [2:0]  rop_reg;
  logic [1:0]  wop_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;

  // Request as seen at the access edge
  logic [2:0]  acc_rop;
  logic [1:0]  acc_wop;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  logic        is_read, is_write;
  logic [1:0]  size;
  logic        in_range;
  logic        suppress;
  logic        do_access;
  logic        ram_we;
  logic [AW-1:0] word_idx;
  logic [3:0]  byte_en;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte [4];
  logic [15:0] rd_half;
  logic [31:0] rdata_next;
  logic [31:0] rdata_reg;

  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      count_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mem_init) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (count_reg == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem_ready = (state_reg == RESP);

  // ------------------------------------------------------ request capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rop_reg   <= 3'd0;
      wop_reg   <= 2'd0;
      addr_reg  <= 32'd0;
      wdata_reg <= 32'd0;
    end else if (accept) begin
      rop_reg   <= mem_read_op;
      wop_reg   <= mem_write_op;
      addr_reg  <= addr;
      wdata_reg <= wdata;
    end
  end

  // With LATENCY=1 the access edge is the accept edge, so the live inputs
  // are used; otherwise the captured copy is used.
  assign acc_rop   = (state_reg == IDLE) ? mem_read_op  : rop_reg;
  assign acc_wop   = (state_reg == IDLE) ? mem_write_op : wop_reg;
  assign acc_addr  = (state_reg == IDLE) ? addr         : addr_reg;
  assign acc_wdata = (state_reg == IDLE) ? wdata        : wdata_reg;

  // --------------------------------------------------------------- decode
  assign is_read  = (acc_rop[1:0] != 2'b00) && (acc_wop == 2'b00);
  assign is_write = (acc_wop != 2'b00) && (acc_rop[1:0] == 2'b00);
  assign size     = is_read ? acc_rop[1:0] : acc_wop;
  assign in_range = (acc_addr[31:2] < DEPTH_W);
  assign word_idx = acc_addr[AW+1:2];

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic misalign_hit;
  logic misaligned_reg;

  assign misalign_hit = (is_read || is_write) &&
                        (((size == 2'b10) && acc_addr[0]) ||
                         ((size == 2'b11) && (acc_addr[1:0] != 2'b00)));
  assign suppress = misalign_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned_reg <= 1'b0;
    end else if (enter_resp && misalign_hit) begin
      misaligned_reg <= 1'b1;
    end
  end

  assign misaligned = misaligned_reg;
`else
  assign suppress   = 1'b0;
  assign misaligned = 1'b0;
`endif

  // reset is folded in so a strobe during reset with LATENCY=1 cannot write.
  assign do_access = enter_resp && reset && in_range && !suppress;
  assign ram_we    = do_access && is_write;

  // ----------------------------------------------------------- byte lanes
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign rd_byte[gi] = rd_word[gi*8 +: 8];
      // Store data is replicated so each lane sees its right-aligned slice.
      assign wr_word[gi*8 +: 8] = (size == 2'b01) ? acc_wdata[7:0] :
                                  (size == 2'b10) ? acc_wdata[(gi%2)*8 +: 8] :
                                                    acc_wdata[gi*8 +: 8];
      assign byte_en[gi] = ram_we &&
                           ((size == 2'b11) ||
                            ((size == 2'b10) && (acc_addr[1] == LANE[1])) ||
                            ((size == 2'b01) && (acc_addr[1:0] == LANE)));
    end
  endgenerate

  // ------------------------------------------------------------------ RAM
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) begin
        mem[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
  end

  assign rd_word = mem[word_idx];
  assign rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

  // ------------------------------------------------------------ load data
  always_comb begin
    rdata_next = 32'd0;
    if (do_access && is_read) begin
      case (acc_rop[1:0])
        2'b01: begin
          if (acc_rop[2]) rdata_next = {24'd0, rd_byte[acc_addr[1:0]]};
          else            rdata_next = {{24{rd_byte[acc_addr[1:0]][7]}}, rd_byte[acc_addr[1:0]]};
        end
        2'b10: begin
          if (acc_rop[2]) rdata_next = {16'd0, rd_half};
          else            rdata_next = {{16{rd_half[15]}}, rd_half};
        end
        2'b11:   rdata_next = rd_word;
        default: rdata_next = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_reg <= 32'd0;
    end else if (enter_resp) begin
      rdata_reg <= rdata_next;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios followed by randomized
// traffic, all checked against a byte-address reference model of the RAM.
module tb_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;
  localparam int REGION  = 64;   // words pre-initialised and used by traffic

  logic        clk;
  logic        reset;
  logic        mem_init;
  logic [2:0]  mem_read_op;
  logic [1:0]  mem_write_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_ready;
  logic [31:0] rdata;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_mem [DEPTH];
  logic        exp_mis = 1'b0;

  mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_init     (mem_init),
    .mem_read_op  (mem_read_op),
    .mem_write_op (mem_write_op),
    .addr         (addr),
    .wdata        (wdata),
    .mem_ready    (mem_ready),
    .rdata        (rdata),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one access to model_mem and returns load data.
  function automatic logic [31:0] model_access(input logic [2:0] rop, input logic [1:0] wop,
                                               input logic [31:0] a, input logic [31:0] wd);
    int     sz, nbytes, lo, off, idx;
    longint lane_mask, mask, v;
    sz = (rop[1:0] != 2'b00) ? int'(rop[1:0]) : int'(wop);
    if ((rop[1:0] != 2'b00) == (wop != 2'b00)) return 32'd0;   // illegal or no-op
    nbytes = 1 << (sz - 1);
    lo     = int'(a[1:0]);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if ((lo % nbytes) != 0) begin
      exp_mis = 1'b1;
      return 32'd0;
    end
`endif
    if (longint'(a >> 2) >= longint'(DEPTH)) return 32'd0;
    idx       = int'(a >> 2);
    off       = (lo / nbytes) * nbytes;
    lane_mask = (longint'(1) << (8 * nbytes)) - 1;
    mask      = lane_mask << (8 * off);
    if (wop != 2'b00) begin
      model_mem[idx] = 32'((longint'(model_mem[idx]) & ~mask) |
                           ((longint'(wd) << (8 * off)) & mask));
      return 32'd0;
    end
    v = (longint'(model_mem[idx]) >> (8 * off)) & lane_mask;
    if (!rop[2] && nbytes < 4 && v[8*nbytes-1]) v = v - (longint'(1) << (8 * nbytes));
    return 32'(v);
  endfunction

  // Issues one request right now (caller is just after a rising edge) and
  // checks latency, data, flag and the single-cycle pulse. Returns with the
  // bench one cycle after mem_ready, i.e. at the earliest legal next request.
  task automatic run_txn(input logic [2:0] rop, input logic [1:0] wop,
                         input logic [31:0] a, input logic [31:0] wd, input bit hold);
    logic [31:0] exp_rd;
    int n;
    exp_rd       = model_access(rop, wop, a, wd);
    mem_read_op  = rop;
    mem_write_op = wop;
    addr         = a;
    wdata        = wd;
    mem_init     = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      // Keep strobing with different request content; all must be ignored.
      mem_read_op  = 3'($urandom);
      mem_write_op = 2'($urandom);
      addr         = $urandom;
      wdata        = $urandom;
    end else begin
      mem_init = 1'b0;
    end
    n = 1;
    while (!mem_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'(LATENCY));
    check("rdata", rdata, exp_rd);
    check("misaligned", {31'd0, misaligned}, {31'd0, exp_mis});
    @(posedge clk); #1;
    mem_init     = 1'b0;
    mem_read_op  = 3'd0;
    mem_write_op = 2'd0;
    check("ready_width", {31'd0, mem_ready}, 32'd0);
    check("rdata_hold", rdata, exp_rd);
    $display("txn rop=%b wop=%b addr=%h wdata=%h hold=%0d -> rdata=%h exp=%h lat=%0d",
             rop, wop, a, wd, hold, rdata, exp_rd, n);
  endtask

  // Reset pulsed while a store is waiting: no pulse, no commit.
  task automatic reset_mid_store(input logic [31:0] a, input logic [31:0] wd);
    int pulses;
    mem_read_op  = 3'd0;
    mem_write_op = 2'b11;
    addr         = a;
    wdata        = wd;
    mem_init     = 1'b1;
    @(posedge clk); #1;
    mem_init     = 1'b0;
    mem_write_op = 2'd0;
    reset        = 1'b0;
    exp_mis      = 1'b0;
    pulses       = 0;
    @(posedge clk); #1;
    if (mem_ready) pulses++;
    check("rst_rdata", rdata, 32'd0);
    check("rst_misaligned", {31'd0, misaligned}, 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (mem_ready) pulses++;
    end
    check("rst_no_ready", 32'(pulses), 32'd0);
    $display("txn reset during store addr=%h wdata=%h pulses=%0d", a, wd, pulses);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [2:0]  rop;
    logic [1:0]  wop;
    int          kind;

    reset        = 1'b0;
    mem_init     = 1'b0;
    mem_read_op  = 3'd0;
    mem_write_op = 2'd0;
    addr         = 32'd0;
    wdata        = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, mem_ready}, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_misaligned", {31'd0, misaligned}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Store and read back with every extension.
    run_txn(3'b000, 2'b11, 32'h10, 32'h8081_82F3, 1'b0);
    run_txn(3'b011, 2'b00, 32'h10, 32'h0, 1'b0);
    check("plan_lw", rdata, 32'h8081_82F3);
    for (int i = 0; i < REGION; i++) begin
      if (i != 4) run_txn(3'b000, 2'b11, 32'(i * 4), $urandom, 1'b0);
    end
    run_txn(3'b001, 2'b00, 32'h10, 32'h0, 1'b0);
    check("plan_lb", rdata, 32'hFFFF_FFF3);
    run_txn(3'b101, 2'b00, 32'h10, 32'h0, 1'b0);
    check("plan_lbu", rdata, 32'h0000_00F3);
    run_txn(3'b010, 2'b00, 32'h12, 32'h0, 1'b0);
    check("plan_lh", rdata, 32'hFFFF_8081);
    run_txn(3'b110, 2'b00, 32'h12, 32'h0, 1'b0);
    check("plan_lhu", rdata, 32'h0000_8081);

    // Partial stores merge into the word.
    run_txn(3'b000, 2'b01, 32'h11, 32'h0000_00AA, 1'b0);
    run_txn(3'b000, 2'b10, 32'h12, 32'h0000_1234, 1'b0);
    run_txn(3'b011, 2'b00, 32'h10, 32'h0, 1'b0);
    check("plan_merge", rdata, 32'h1234_AAF3);

    // Misaligned word load.
    run_txn(3'b011, 2'b00, 32'h13, 32'h0, 1'b0);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    check("plan_mis_rdata", rdata, 32'h0);
    check("plan_mis_flag", {31'd0, misaligned}, 32'd1);
`else
    check("plan_mis_rdata", rdata, 32'h1234_AAF3);
    check("plan_mis_flag", {31'd0, misaligned}, 32'd0);
`endif

    // Strobe held high, out of range, no wrap into word 0.
    run_txn(3'b011, 2'b00, 32'(DEPTH * 4), 32'h0, 1'b1);
    check("oor_load", rdata, 32'h0);
    run_txn(3'b000, 2'b11, 32'(DEPTH * 4), 32'hDEAD_BEEF, 1'b1);
    run_txn(3'b011, 2'b00, 32'h0, 32'h0, 1'b1);
    run_txn(3'b011, 2'b11, 32'h0, 32'hFFFF_FFFF, 1'b0);   // illegal: no write
    run_txn(3'b100, 2'b00, 32'h0, 32'hFFFF_FFFF, 1'b0);   // no-op
    run_txn(3'b011, 2'b00, 32'h0, 32'h0, 1'b0);

    // Reset during a store.
    reset_mid_store(32'h20, 32'h5555_5555);
    run_txn(3'b011, 2'b00, 32'h20, 32'h0, 1'b0);

    // Randomized traffic.
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 9);
      a    = {24'd0, 6'($urandom_range(0, REGION - 1)), 2'($urandom)};
      wd   = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        rop = {1'($urandom), 2'($urandom_range(1, 3))};
        wop = 2'b00;
      end else begin
        rop = {1'($urandom), 2'b00};
        wop = 2'($urandom_range(1, 3));
      end
      if (kind == 0) a = (t % 2 == 0) ? 32'(DEPTH * 4 + $urandom_range(0, 255)) : ($urandom | 32'h8000_0000);
      if (kind == 7) begin rop = {1'($urandom), 2'b00}; wop = 2'b00; end
      if (kind == 8) begin rop = {1'($urandom), 2'($urandom_range(1, 3))}; wop = 2'($urandom_range(1, 3)); end
      run_txn(rop, wop, a, wd, (kind == 9));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
